// File: rtl/johnson_decoder_pkg.sv
// Shared types and helpers for Johnson-code checking and decoding.
package johnson_pkg;
  localparam int JC_WIDTH = 4;                 // Johnson register width
  localparam int JC_LEN   = 2 * JC_WIDTH;      // sequence length
  localparam int JC_IDX_W = $clog2(JC_LEN);    // step index width

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} jd_state_t;

  typedef struct packed {
    logic                legal;
    logic [JC_IDX_W-1:0] index;
  } jc_dec_t;

  // Successor codeword: shift right, feeding the inverted LSB into the MSB.
  function automatic logic [JC_WIDTH-1:0] jc_next(input logic [JC_WIDTH-1:0] c);
    return {~c[0], c[JC_WIDTH-1:1]};
  endfunction

  // Legal words have a single run of ones anchored at the MSB (MSB=1) or at
  // the LSB (MSB=0, all-zeros included). Index follows from the popcount.
  function automatic jc_dec_t jc_decode(input logic [JC_WIDTH-1:0] c);
    jc_dec_t r;
    logic    seen0;
    int      ones;
    r.legal = 1'b1;
    seen0   = 1'b0;
    ones    = 0;
    for (int i = 0; i < JC_WIDTH; i++) begin
      // walk away from the anchored end; a one after a zero breaks the run
      int b;
      b = c[JC_WIDTH-1] ? (JC_WIDTH - 1 - i) : i;
      if (!c[b]) seen0 = 1'b1;
      else if (seen0) r.legal = 1'b0;
      if (c[i]) ones++;
    end
    if (c[JC_WIDTH-1]) r.index = JC_IDX_W'(ones);
    else               r.index = JC_IDX_W'((JC_LEN - ones) % JC_LEN);
    return r;
  endfunction
endpackage

// File: rtl/johnson_decoder_if.sv
// Johnson-code sample bus: codeword in, decode/status out.
interface johnson_decoder_if;
  import johnson_pkg::*;
  logic [JC_WIDTH-1:0] code_in;
  logic                code_valid;
  logic [JC_IDX_W-1:0] index_out;
  logic                index_valid;
  logic                illegal;
  logic                skip;
  logic                locked;
  logic [7:0]          err_count;

  modport master (output code_in, code_valid,
                  input  index_out, index_valid, illegal, skip, locked, err_count);
  modport slave  (input  code_in, code_valid,
                  output index_out, index_valid, illegal, skip, locked, err_count);
endinterface

// File: rtl/johnson_decoder_code_lut.sv
// Combinational Johnson codeword legality check and binary decode.
module johnson_code_lut
  import johnson_pkg::*;
(
  input  logic [JC_WIDTH-1:0] code,
  output logic                legal,
  output logic [JC_IDX_W-1:0] index
);
  jc_dec_t dec;

  // thin wrapper so other checkers can share the same decode
  always_comb begin
    dec   = jc_decode(code);
    legal = dec.legal;
    index = dec.index;
  end
endmodule

// File: rtl/johnson_decoder.sv
// Samples Johnson codewords, decodes them, and tracks lock to the sequence.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = JC_WIDTH,
  parameter int LOCK_LEN = 2,            // 1..15
  localparam int IDX_W   = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  johnson_decoder_if.slave   bus
);
  localparam int RUN_W = 4;

  jd_state_t        state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             index_valid_q, index_valid_d;
  logic             illegal_q, illegal_d;
  logic             skip_q, skip_d;
  logic             locked_q, locked_d;
  logic [7:0]       err_q, err_d;
  logic             err_inc;

  logic             lut_legal;
  logic [IDX_W-1:0] lut_index;
  logic             is_next;

  johnson_code_lut u_lut (
    .code  (bus.code_in),
    .legal (lut_legal),
    .index (lut_index)
  );

  assign is_next = (bus.code_in == jc_next(prev_q));

  // Next-state, sample bookkeeping and output pulses
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    run_d         = run_q;
    index_d       = index_q;
    index_valid_d = 1'b0;
    illegal_d     = 1'b0;
    skip_d        = 1'b0;
    err_inc       = 1'b0;
    if (bus.code_valid) begin
      if (!lut_legal) begin
        illegal_d = 1'b1;
        err_inc   = 1'b1;
        state_d   = IDLE;
        run_d     = '0;
      end else begin
        index_d       = lut_index;
        index_valid_d = 1'b1;
        prev_d        = bus.code_in;
        unique case (state_q)
          IDLE: begin
            state_d = ACQUIRE;
            run_d   = '0;
          end
          ACQUIRE: begin
            // a mismatch while acquiring just reseeds, no skip
            if (is_next) begin
              run_d = run_q + RUN_W'(1);
              if (run_d == RUN_W'(LOCK_LEN)) state_d = LOCKED;
            end else begin
              run_d = '0;
            end
          end
          LOCKED: begin
            if (!is_next) begin
              skip_d  = 1'b1;
              err_inc = 1'b1;
              state_d = ACQUIRE;
              run_d   = '0;
            end
          end
          default: begin
            state_d = IDLE;
            run_d   = '0;
          end
        endcase
      end
    end
    err_d    = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    // registered from next state so it moves with the matching pulse
    locked_d = (state_d == LOCKED);
  end

  // State and output registers, synchronous reset has priority over samples
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      run_q         <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      skip_q        <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      illegal_q     <= illegal_d;
      skip_q        <= skip_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign bus.index_out   = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.illegal     = illegal_q;
  assign bus.skip        = skip_q;
  assign bus.locked      = locked_q;
  assign bus.err_count   = err_q;
endmodule
